// File: rtl/mmc1x_mapper_if.sv
// mmc1x_mapper_if: CPU/PPU-side bus bundle for the mmc1x_mapper serial-load
// bank mapper. The clock (M2) and reset (nRES) stay plain module ports.
//   nROMSEL, CPU_RnW, CPU_A14, CPU_A13 : CPU cycle type and register select
//   CPU_D7, CPU_D0                     : load-abort bit and serial data bit
//   PPU_A12, PPU_A11, PPU_A10          : PPU address bits for CHR/mirroring
//   PRG_A, CHR_A                       : PRG/CHR bank address lines
//   CIRAM_A10                          : nametable select
//   PRG_nCE, SRAM_CE                   : PRG ROM / work-RAM chip enables
// master = the CPU/PPU/board side, slave = the mapper.
// PRG_BITS/CHR_BITS must match the parameters of the connected mapper.
interface mmc1x_mapper_if #(
    parameter int PRG_BITS = 4,
    parameter int CHR_BITS = 5
);
    logic                nROMSEL;
    logic                CPU_RnW;
    logic                CPU_A14;
    logic                CPU_A13;
    logic                CPU_D7;
    logic                CPU_D0;
    logic                PPU_A12;
    logic                PPU_A11;
    logic                PPU_A10;
    logic [PRG_BITS-1:0] PRG_A;
    logic [CHR_BITS-1:0] CHR_A;
    logic                CIRAM_A10;
    logic                PRG_nCE;
    logic                SRAM_CE;

    modport master (
        output nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
        output PPU_A12, PPU_A11, PPU_A10,
        input  PRG_A, CHR_A, CIRAM_A10, PRG_nCE, SRAM_CE
    );

    modport slave (
        input  nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
        input  PPU_A12, PPU_A11, PPU_A10,
        output PRG_A, CHR_A, CIRAM_A10, PRG_nCE, SRAM_CE
    );
endinterface

// File: rtl/mmc1x_mapper.sv
// mmc1x_mapper: MMC1-style serial-load bank mapper, single clock (M2).
// CPU writes to $8000-$FFFF shift CPU_D0 in LSB first; CPU_D7=1 aborts the
// load. A completed SHIFT_LEN-bit load commits to ctrl/chr0/chr1/prg chosen by
// CPU_A14:A13. Those registers drive PRG_A, CHR_A, CIRAM_A10 and SRAM_CE.
// Ports:
//   M2   : clock, all state updates on the rising edge
//   nRES : synchronous active-low reset
//   bus  : mmc1x_mapper_if slave modport (CPU/PPU inputs, bank/enable outputs)
module mmc1x_mapper #(
    parameter int SHIFT_LEN     = 5,
    parameter int PRG_BITS      = 4,
    parameter int CHR_BITS      = 5,
    parameter int FILTER_CONSEC = 1
) (
    input  logic                  M2,
    input  logic                  nRES,
    mmc1x_mapper_if.slave         bus
);
    localparam int CW = $clog2(SHIFT_LEN);
    localparam logic [CW-1:0] LAST = CW'(SHIFT_LEN - 1);

    logic [SHIFT_LEN-1:0] shift;
    logic [CW-1:0]        count;
    logic                 prev_wr;
    logic [SHIFT_LEN-1:0] ctrl;
    logic [SHIFT_LEN-1:0] chr0;
    logic [SHIFT_LEN-1:0] chr1;
    logic [SHIFT_LEN-1:0] prg;

    logic                 wr;
    logic                 accept;
    logic [SHIFT_LEN-1:0] shifted;

    // Bank fields widened to 8 bits, then cut to the output width; this gives
    // zero-extension or truncation for any legal parameter combination.
    logic [7:0]           pb_ext;
    logic [7:0]           c0_ext;
    logic [7:0]           c1_ext;
    logic [PRG_BITS-1:0]  pb;
    logic [CHR_BITS-1:0]  c0;
    logic [CHR_BITS-1:0]  c1;
    logic                 wram_dis;
    logic                 unused_bits;

    assign wr      = !bus.nROMSEL && !bus.CPU_RnW;
    // The write cycle right after another write cycle is dropped (RMW filter).
    assign accept  = wr && !((FILTER_CONSEC != 0) && prev_wr);
    assign shifted = {bus.CPU_D0, shift[SHIFT_LEN-1:1]};

    always_ff @(posedge M2) begin
        if (!nRES) begin
            shift   <= '0;
            count   <= '0;
            prev_wr <= 1'b0;
            ctrl    <= SHIFT_LEN'(12);
            chr0    <= '0;
            chr1    <= '0;
            prg     <= '0;
        end else begin
            prev_wr <= wr;
            if (accept) begin
                if (bus.CPU_D7) begin
                    // Abort takes priority even over a completing write.
                    shift     <= '0;
                    count     <= '0;
                    ctrl[3:2] <= 2'b11;
                end else if (count == LAST) begin
                    shift <= '0;
                    count <= '0;
                    case ({bus.CPU_A14, bus.CPU_A13})
                        2'b00:   ctrl <= shifted;
                        2'b01:   chr0 <= shifted;
                        2'b10:   chr1 <= shifted;
                        default: prg  <= shifted;
                    endcase
                end else begin
                    shift <= shifted;
                    count <= count + CW'(1);
                end
            end
        end
    end

    assign pb_ext   = 8'(prg[SHIFT_LEN-2:0]);
    assign c0_ext   = 8'(chr0);
    assign c1_ext   = 8'(chr1);
    assign pb       = pb_ext[PRG_BITS-1:0];
    assign c0       = c0_ext[CHR_BITS-1:0];
    assign c1       = c1_ext[CHR_BITS-1:0];
    assign wram_dis = prg[SHIFT_LEN-1];

    // Bits that exist only to be stored (upper ctrl bits, widening padding).
    assign unused_bits = ^{pb_ext, c0_ext, c1_ext, ctrl};

    always_comb begin
        case (ctrl[3:2])
            2'b00, 2'b01: bus.PRG_A = {pb[PRG_BITS-1:1], bus.CPU_A14};
            2'b10:        bus.PRG_A = bus.CPU_A14 ? pb : '0;
            default:      bus.PRG_A = bus.CPU_A14 ? '1 : pb;
        endcase
    end

    always_comb begin
        if (ctrl[4]) begin
            bus.CHR_A = bus.PPU_A12 ? c1 : c0;
        end else begin
            bus.CHR_A = {c0[CHR_BITS-1:1], bus.PPU_A12};
        end
    end

    always_comb begin
        case (ctrl[1:0])
            2'b00:   bus.CIRAM_A10 = 1'b0;
            2'b01:   bus.CIRAM_A10 = 1'b1;
            2'b10:   bus.CIRAM_A10 = bus.PPU_A10;
            default: bus.CIRAM_A10 = bus.PPU_A11;
        endcase
    end

    assign bus.PRG_nCE = bus.nROMSEL || !bus.CPU_RnW;
    assign bus.SRAM_CE = bus.nROMSEL && bus.CPU_A14 && bus.CPU_A13 && !wram_dis;
endmodule

// File: tb/tb_mmc1x_mapper.sv
// tb_mmc1x_mapper: directed bench for mmc1x_mapper with three instances:
//   u0: defaults (SHIFT_LEN=5, PRG_BITS=4, CHR_BITS=5, FILTER_CONSEC=1)
//   u1: FILTER_CONSEC=0
//   u2: SHIFT_LEN=8, PRG_BITS=7
// Each instance has its own nROMSEL so a write targets exactly one of them.
// Stimulus pushes expected outputs into a scoreboard queue; a monitor on the
// falling clock edge pops and compares against the selected DUT output.
module tb_mmc1x_mapper;
    localparam int F_PRG  = 0;
    localparam int F_CHR  = 1;
    localparam int F_CIR  = 2;
    localparam int F_NCE  = 3;
    localparam int F_SRAM = 4;

    typedef struct {
        int         d;
        int         fld;
        logic [7:0] exp;
        string      nm;
    } exp_t;

    logic       clk;
    logic       nres;
    logic [2:0] nromsel;
    logic       rnw, a14, a13, d7, d0, p12, p11, p10;

    exp_t sb[$];
    int   checks;
    int   failures;

    mmc1x_mapper_if #(.PRG_BITS(4), .CHR_BITS(5)) bus0();
    mmc1x_mapper_if #(.PRG_BITS(4), .CHR_BITS(5)) bus1();
    mmc1x_mapper_if #(.PRG_BITS(7), .CHR_BITS(5)) bus2();

    assign bus0.nROMSEL = nromsel[0];
    assign bus1.nROMSEL = nromsel[1];
    assign bus2.nROMSEL = nromsel[2];
    assign {bus0.CPU_RnW, bus1.CPU_RnW, bus2.CPU_RnW} = {3{rnw}};
    assign {bus0.CPU_A14, bus1.CPU_A14, bus2.CPU_A14} = {3{a14}};
    assign {bus0.CPU_A13, bus1.CPU_A13, bus2.CPU_A13} = {3{a13}};
    assign {bus0.CPU_D7,  bus1.CPU_D7,  bus2.CPU_D7}  = {3{d7}};
    assign {bus0.CPU_D0,  bus1.CPU_D0,  bus2.CPU_D0}  = {3{d0}};
    assign {bus0.PPU_A12, bus1.PPU_A12, bus2.PPU_A12} = {3{p12}};
    assign {bus0.PPU_A11, bus1.PPU_A11, bus2.PPU_A11} = {3{p11}};
    assign {bus0.PPU_A10, bus1.PPU_A10, bus2.PPU_A10} = {3{p10}};

    mmc1x_mapper #(.SHIFT_LEN(5), .PRG_BITS(4), .CHR_BITS(5), .FILTER_CONSEC(1))
        u0 (.M2(clk), .nRES(nres), .bus(bus0));
    mmc1x_mapper #(.SHIFT_LEN(5), .PRG_BITS(4), .CHR_BITS(5), .FILTER_CONSEC(0))
        u1 (.M2(clk), .nRES(nres), .bus(bus1));
    mmc1x_mapper #(.SHIFT_LEN(8), .PRG_BITS(7), .CHR_BITS(5), .FILTER_CONSEC(1))
        u2 (.M2(clk), .nRES(nres), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] read_out(int d, int f);
        logic [7:0] v;
        v = '0;
        case (d)
            0: case (f)
                   F_PRG:   v = 8'(bus0.PRG_A);
                   F_CHR:   v = 8'(bus0.CHR_A);
                   F_CIR:   v = 8'(bus0.CIRAM_A10);
                   F_NCE:   v = 8'(bus0.PRG_nCE);
                   default: v = 8'(bus0.SRAM_CE);
               endcase
            1: case (f)
                   F_PRG:   v = 8'(bus1.PRG_A);
                   F_CHR:   v = 8'(bus1.CHR_A);
                   F_CIR:   v = 8'(bus1.CIRAM_A10);
                   F_NCE:   v = 8'(bus1.PRG_nCE);
                   default: v = 8'(bus1.SRAM_CE);
               endcase
            default: case (f)
                   F_PRG:   v = 8'(bus2.PRG_A);
                   F_CHR:   v = 8'(bus2.CHR_A);
                   F_CIR:   v = 8'(bus2.CIRAM_A10);
                   F_NCE:   v = 8'(bus2.PRG_nCE);
                   default: v = 8'(bus2.SRAM_CE);
               endcase
        endcase
        return v;
    endfunction

    // Monitor: drains everything queued during the preceding half cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = read_out(e.d, e.fld);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s (u%0d): got 0x%0h expected 0x%0h", e.nm, e.d, act, e.exp);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wr_cycle(int d, bit wa14, bit wa13, bit wd7, bit wd0);
        nromsel    = '1;
        nromsel[d] = 1'b0;
        rnw = 1'b0; a14 = wa14; a13 = wa13; d7 = wd7; d0 = wd0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        nromsel = '1;
        rnw = 1'b1; d7 = 1'b0; d0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load(int d, bit wa14, bit wa13, logic [7:0] v, int n);
        for (int i = 0; i < n; i++) begin
            wr_cycle(d, wa14, wa13, 1'b0, v[i]);
            idle();
        end
    endtask

    task automatic chk(int d, bit nrom, bit ca14, bit ca13, bit c12, bit c11, bit c10,
                       int fld, logic [7:0] exp, string nm);
        exp_t e;
        nromsel    = '1;
        nromsel[d] = nrom;
        rnw = 1'b1; d7 = 1'b0; d0 = 1'b0;
        a14 = ca14; a13 = ca13; p12 = c12; p11 = c11; p10 = c10;
        e.d = d; e.fld = fld; e.exp = exp; e.nm = nm;
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        nres = 1'b0; nromsel = '1; rnw = 1'b1;
        a14 = 0; a13 = 0; d7 = 0; d0 = 0; p12 = 0; p11 = 0; p10 = 0;
        repeat (3) @(posedge clk);
        #1 nres = 1'b1;
        idle();

        // Reset state
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h00, "rst_prg_lo");
        chk(0, 0, 1, 0, 0, 0, 0, F_PRG,  8'h0F, "rst_prg_hi");
        chk(0, 0, 0, 0, 1, 0, 0, F_CHR,  8'h01, "rst_chr_a12_1");
        chk(0, 0, 0, 0, 0, 0, 0, F_CHR,  8'h00, "rst_chr_a12_0");
        chk(0, 0, 0, 0, 0, 1, 1, F_CIR,  8'h00, "rst_ciram");
        chk(0, 0, 0, 0, 0, 0, 0, F_NCE,  8'h00, "nce_rom_read");
        chk(0, 1, 0, 0, 0, 0, 0, F_NCE,  8'h01, "nce_no_rom");
        chk(2, 0, 1, 0, 0, 0, 0, F_PRG,  8'h7F, "rst_prg_hi_w7");

        // prg = 5 via $E000; not visible before the fifth write
        load(0, 1, 1, 8'h05, 4);
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h00, "prg_before_commit");
        wr_cycle(0, 1, 1, 1'b0, 1'b0);
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h05, "prg5_lo");
        chk(0, 0, 1, 0, 0, 0, 0, F_PRG,  8'h0F, "prg5_hi");
        chk(0, 1, 1, 1, 0, 0, 0, F_SRAM, 8'h01, "sram_en");

        // ctrl = 0x12, chr0 = 3, chr1 = 9
        load(0, 0, 0, 8'h12, 5);
        load(0, 0, 1, 8'h03, 5);
        load(0, 1, 0, 8'h09, 5);
        chk(0, 0, 0, 0, 0, 0, 0, F_CHR,  8'h03, "chr4k_lo");
        chk(0, 0, 0, 0, 1, 0, 0, F_CHR,  8'h09, "chr4k_hi");
        chk(0, 0, 0, 0, 0, 0, 1, F_CIR,  8'h01, "vmirror_a10_1");
        chk(0, 0, 0, 0, 0, 1, 0, F_CIR,  8'h00, "vmirror_a10_0");
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h04, "prg32k_lo");
        chk(0, 0, 1, 0, 0, 0, 0, F_PRG,  8'h05, "prg32k_hi");

        // Abort after three bits, then a clean load of chr0 = 7
        load(0, 0, 0, 8'h07, 3);
        wr_cycle(0, 0, 0, 1'b1, 1'b0);
        idle();
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h05, "abort_mode3_lo");
        chk(0, 0, 1, 0, 0, 0, 0, F_PRG,  8'h0F, "abort_mode3_hi");
        chk(0, 0, 0, 0, 0, 0, 1, F_CIR,  8'h01, "abort_keeps_mirror");
        load(0, 0, 1, 8'h07, 5);
        chk(0, 0, 0, 0, 0, 0, 0, F_CHR,  8'h07, "chr0_after_abort");
        chk(0, 0, 0, 0, 1, 0, 0, F_CHR,  8'h09, "chr1_kept");

        // Back-to-back writes: filtered on u0, both accepted on u1
        wr_cycle(0, 1, 0, 1'b0, 1'b1);
        wr_cycle(0, 1, 0, 1'b0, 1'b1);
        idle();
        load(0, 1, 0, 8'h00, 4);
        chk(0, 0, 0, 0, 1, 0, 0, F_CHR,  8'h01, "filter_on_chr1");
        load(1, 0, 0, 8'h10, 5);
        wr_cycle(1, 1, 0, 1'b0, 1'b1);
        wr_cycle(1, 1, 0, 1'b0, 1'b1);
        idle();
        load(1, 1, 0, 8'h00, 3);
        chk(1, 0, 0, 0, 1, 0, 0, F_CHR,  8'h03, "filter_off_chr1");

        // Work-RAM disable
        load(0, 1, 1, 8'h15, 5);
        chk(0, 1, 1, 1, 0, 0, 0, F_SRAM, 8'h00, "wram_dis");
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h05, "prg_with_wram_dis");

        // SHIFT_LEN=8 / PRG_BITS=7: bank 0x55
        load(2, 1, 1, 8'h55, 7);
        chk(2, 0, 0, 0, 0, 0, 0, F_PRG,  8'h00, "w8_before_commit");
        wr_cycle(2, 1, 1, 1'b0, 1'b0);
        chk(2, 0, 0, 0, 0, 0, 0, F_PRG,  8'h55, "w8_prg_lo");
        chk(2, 0, 1, 0, 0, 0, 0, F_PRG,  8'h7F, "w8_prg_hi");
        chk(2, 1, 1, 1, 0, 0, 0, F_SRAM, 8'h01, "w8_sram_en");

        // Reset mid-load, with a write presented during the reset cycle
        load(0, 0, 1, 8'h07, 3);
        nres = 1'b0;
        wr_cycle(0, 0, 1, 1'b0, 1'b1);
        nres = 1'b1;
        idle();
        chk(0, 0, 0, 0, 0, 0, 0, F_PRG,  8'h00, "rst2_prg_lo");
        chk(0, 0, 1, 0, 0, 0, 0, F_PRG,  8'h0F, "rst2_prg_hi");
        chk(0, 0, 0, 0, 1, 0, 0, F_CHR,  8'h01, "rst2_chr");
        chk(0, 0, 0, 0, 0, 1, 1, F_CIR,  8'h00, "rst2_ciram");
        chk(0, 1, 1, 1, 0, 0, 0, F_SRAM, 8'h01, "rst2_sram");
        chk(2, 0, 0, 0, 0, 0, 0, F_PRG,  8'h00, "rst2_w8_prg");
        load(0, 0, 1, 8'h06, 5);
        chk(0, 0, 0, 0, 0, 0, 0, F_CHR,  8'h06, "chr0_after_rst");
        chk(0, 0, 0, 0, 1, 0, 0, F_CHR,  8'h07, "chr0_after_rst_a12");

        idle();
        idle();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
